// File: rtl/field_lock_ctrl_if.sv
// Command and cell-evaluation bus between the lock controller and its environment.
interface field_lock_ctrl_if #(
    parameter int unsigned FIELD_W = 20,
    parameter int unsigned FIELD_H = 20
);
    localparam int unsigned FIELD_BITS = FIELD_W * FIELD_H;
    localparam int unsigned IDX_W      = 9;

    logic                  cmd_valid;
    logic [1:0]            cmd_op;
    logic                  cmd_ready;
    logic [1:0]            cell_bx;
    logic [1:0]            cell_by;
    logic                  cell_bit;
    logic [IDX_W-1:0]      cell_index;
    logic                  cell_oob;
    logic [FIELD_BITS-1:0] field_background;
    logic                  done;
    logic                  collide;
    logic [2:0]            lines_cleared;

    // Command issuer plus the external index/rotate unit
    modport master (
        output cmd_valid, cmd_op, cell_bit, cell_index, cell_oob,
        input  cmd_ready, cell_bx, cell_by, field_background, done, collide, lines_cleared
    );

    // Lock controller
    modport slave (
        input  cmd_valid, cmd_op, cell_bit, cell_index, cell_oob,
        output cmd_ready, cell_bx, cell_by, field_background, done, collide, lines_cleared
    );
endinterface

// File: rtl/field_lock_ctrl.sv
// Playfield lock controller: collision check, piece lock, full-row removal and clear.
module field_lock_ctrl #(
    parameter int unsigned FIELD_W = 20,
    parameter int unsigned FIELD_H = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    field_lock_ctrl_if.slave  bus
);
    localparam int unsigned FIELD_BITS = FIELD_W * FIELD_H;
    localparam int unsigned IDX_W      = 9;
    localparam int unsigned ROW_W      = (FIELD_H > 1) ? $clog2(FIELD_H) : 1;

    localparam logic [1:0] OP_CHECK = 2'b00;
    localparam logic [1:0] OP_LOCK  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    // S_CLR is the single working cycle of a CLEAR command
    typedef enum logic [2:0] {
        S_IDLE, S_CHK, S_WR, S_SCAN, S_SHIFT, S_CLR, S_FIN
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            k_q, k_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic                  is_lock_q, is_lock_d;
    logic [FIELD_BITS-1:0] field_q, field_d;
    logic                  collide_q, collide_d;
    logic [2:0]            lines_q, lines_d;
    logic                  ready_q, done_q;
    logic [1:0]            bx_q, by_q;

    logic                  idx_in_range_c;
    logic                  cell_live_c;
    logic                  cell_hit_c;
    logic [IDX_W-1:0]      row_base_c;
    logic                  row_full_c;

    // Cell qualification: an index is trusted only for in-field set bits
    assign idx_in_range_c = (32'(bus.cell_index) < FIELD_BITS);
    assign cell_live_c    = bus.cell_bit & ~bus.cell_oob & idx_in_range_c;
    assign cell_hit_c     = bus.cell_bit &
                            (bus.cell_oob | (idx_in_range_c & field_q[bus.cell_index]));

    // Fullness of the row currently being scanned
    assign row_base_c = IDX_W'(row_q) * IDX_W'(FIELD_W);
    assign row_full_c = &field_q[row_base_c +: FIELD_W];

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        row_d     = row_q;
        is_lock_d = is_lock_q;
        field_d   = field_q;
        collide_d = collide_q;
        lines_d   = lines_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    collide_d = 1'b0;
                    lines_d   = 3'd0;
                    k_d       = 4'd0;
                    row_d     = ROW_W'(FIELD_H - 1);
                    is_lock_d = (bus.cmd_op == OP_LOCK);
                    case (bus.cmd_op)
                        OP_CHECK, OP_LOCK: state_d = S_CHK;
                        OP_CLEAR:          state_d = S_CLR;
                        default:           state_d = S_FIN;
                    endcase
                end
            end
            S_CHK: begin
                if (cell_hit_c) begin
                    collide_d = 1'b1;
                end
                k_d = k_q + 4'd1;
                if (k_q == 4'd15) begin
                    if (is_lock_q && !(collide_q || cell_hit_c)) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_WR: begin
                if (cell_live_c) begin
                    field_d[bus.cell_index] = 1'b1;
                end
                k_d = k_q + 4'd1;
                if (k_q == 4'd15) begin
                    state_d = S_SCAN;
                    row_d   = ROW_W'(FIELD_H - 1);
                end
            end
            S_SCAN: begin
                if (row_full_c) begin
                    state_d = S_SHIFT;
                end else if (row_q == '0) begin
                    state_d = S_FIN;
                end else begin
                    row_d = row_q - ROW_W'(1);
                end
            end
            S_SHIFT: begin
                // Rows above the full row drop by one; the top row refills empty
                for (int unsigned i = 1; i < FIELD_H; i++) begin
                    if (i <= 32'(row_q)) begin
                        field_d[i*FIELD_W +: FIELD_W] = field_q[(i-1)*FIELD_W +: FIELD_W];
                    end
                end
                field_d[0 +: FIELD_W] = '0;
                if (lines_q != 3'd7) begin
                    lines_d = lines_q + 3'd1;
                end
                state_d = S_SCAN;
            end
            S_CLR: begin
                field_d = '0;
                state_d = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            k_q       <= 4'd0;
            row_q     <= '0;
            is_lock_q <= 1'b0;
            field_q   <= '0;
            collide_q <= 1'b0;
            lines_q   <= 3'd0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            bx_q      <= 2'd0;
            by_q      <= 2'd0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            row_q     <= row_d;
            is_lock_q <= is_lock_d;
            field_q   <= field_d;
            collide_q <= collide_d;
            lines_q   <= lines_d;
            ready_q   <= (state_d == S_IDLE);
            done_q    <= (state_d == S_FIN);
            if (state_d == S_CHK || state_d == S_WR) begin
                bx_q <= k_d[1:0];
                by_q <= k_d[3:2];
            end else begin
                bx_q <= 2'd0;
                by_q <= 2'd0;
            end
        end
    end

    assign bus.cmd_ready        = ready_q;
    assign bus.done             = done_q;
    assign bus.collide          = collide_q;
    assign bus.lines_cleared    = lines_q;
    assign bus.field_background = field_q;
    assign bus.cell_bx          = bx_q;
    assign bus.cell_by          = by_q;
endmodule
